fpm_uart_ctrl: RTL and testbench

Sequencing controller between the UART byte receiver, the single-precision FP multiplier and the UART byte transmitter.
- Collects 8 received bytes into operands A and B, both big-endian.
- Pulses the multiplier start and waits for done.
- Sends the 4 result bytes back through the transmitter, MSB first.
- Sits at top level as the only client of all three blocks. Provides an inter-byte timeout so a broken frame cannot desynchronise the host protocol.

---
 rtl/fpm_pkg.sv | 21 ++
 rtl/fpm_byte_timeout.sv | 35 +++
 rtl/fpm_uart_ctrl.sv | 143 ++++++++++++++
 tb/tb_fpm_uart_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared definitions for the UART <-> FP multiplier sequencing controller.
package fpm_pkg;

  typedef enum logic [2:0] {
    s_RX       = 3'd0,
    s_START    = 3'd1,
    s_WAIT_MUL = 3'd2,
    s_TX_LOAD  = 3'd3,
    s_TX_WAIT  = 3'd4
  } fpm_state_e;

  localparam int FRAME_BYTES  = 8;
  localparam int RESULT_BYTES = 4;
  localparam bit BIG_ENDIAN   = 1'b1;

  // Bit offset of byte idx inside a 32-bit word, byte 0 being the MSB.
  function automatic logic [4:0] be_lsb(input logic [1:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/fpm_byte_timeout.sv
// Loadable up-counter with clear that raises a single-cycle expiry and restarts from zero.
module fpm_byte_timeout #(
  parameter int LIMIT = 3999,
  parameter int CNT_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear and load take priority, so an event on the expiry cycle suppresses it.
  assign o_expire = i_en && !i_clr && !i_load && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)         cnt_d = '0;
    else if (i_load)   cnt_d = i_load_val;
    else if (o_expire) cnt_d = '0;
    else if (i_en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fpm_uart_ctrl.sv
// Frames 8 UART bytes into two FP operands, runs the multiplier, and streams the 4 result bytes back.
module fpm_uart_ctrl
  import fpm_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 4000,
  parameter int CNT_W        = 16
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [31:0] o_Op_A,
  output logic [31:0] o_Op_B,
  output logic        o_Mul_Start,
  input  logic        i_Mul_Done,
  input  logic [31:0] i_Mul_Result,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  output logic [31:0] o_Result,
  output logic        o_Busy,
  output logic        o_Frame_Err
);

  fpm_state_e  state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  j_q, j_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]  txb_q, txb_d;
  logic        start_q, start_d, txdv_q, txdv_d, busy_q, busy_d, err_q, err_d;
  logic        tmo_clr, tmo_en, tmo_exp;

  fpm_byte_timeout #(.LIMIT(TIMEOUT_CLKS - 1), .CNT_W(CNT_W)) u_tmo (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_clr     (tmo_clr),
    .i_en      (tmo_en),
    .i_load    (1'b0),
    .i_load_val({CNT_W{1'b0}}),
    .o_expire  (tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    txb_d   = txb_q;
    start_d = 1'b0;
    txdv_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_q != s_RX);
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      s_RX: begin
        tmo_en = (k_q != 3'd0);
        if (i_Rx_DV) begin
          tmo_clr = 1'b1;
          if (!k_q[2]) a_d[be_lsb(k_q[1:0]) +: 8] = i_Rx_Byte;
          else         b_d[be_lsb(k_q[1:0]) +: 8] = i_Rx_Byte;
          if (k_q == 3'(FRAME_BYTES - 1)) begin
            k_d     = 3'd0;
            state_d = s_START;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else if (tmo_exp) begin
          // Partial operand bytes are left in place; the next frame overwrites them.
          k_d   = 3'd0;
          err_d = 1'b1;
        end
      end
      s_START: begin
        start_d = 1'b1;
        state_d = s_WAIT_MUL;
      end
      s_WAIT_MUL: begin
        if (i_Mul_Done) begin
          res_d   = i_Mul_Result;
          j_d     = 2'd0;
          state_d = s_TX_LOAD;
        end
      end
      s_TX_LOAD: begin
        txdv_d  = 1'b1;
        txb_d   = res_q[be_lsb(j_q) +: 8];
        state_d = s_TX_WAIT;
      end
      s_TX_WAIT: begin
        if (i_Tx_Done) begin
          if (j_q == 2'(RESULT_BYTES - 1)) begin
            state_d = s_RX;
          end else begin
            j_d     = j_q + 2'd1;
            state_d = s_TX_LOAD;
          end
        end
      end
      default: state_d = s_RX;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= s_RX;
      k_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      txb_q   <= '0;
      start_q <= 1'b0;
      txdv_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      txb_q   <= txb_d;
      start_q <= start_d;
      txdv_q  <= txdv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_Op_A      = a_q;
  assign o_Op_B      = b_q;
  assign o_Mul_Start = start_q;
  assign o_Tx_DV     = txdv_q;
  assign o_Tx_Byte   = txb_q;
  assign o_Result    = res_q;
  assign o_Busy      = busy_q;
  assign o_Frame_Err = err_q;

endmodule

// File: tb/tb_fpm_uart_ctrl.sv
// Directed-plus-random bench: frames are built from byte lists and the expected operands,
// pulse timing and result byte stream are derived from the frame contents.
module tb_fpm_uart_ctrl;

  localparam int T = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [31:0] op_a, op_b, result;
  logic        mul_start, tx_dv, busy, frame_err;
  logic        mul_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic [7:0]  tx_byte;
  logic        tx_done = 1'b0;

  int nchk = 0;
  int nerr = 0;
  int st_cnt = 0, tx_cnt = 0, er_cnt = 0;
  logic [31:0] exp_a = '0;
  logic [63:0] fr;

  fpm_uart_ctrl #(.TIMEOUT_CLKS(T), .CNT_W(16)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Op_A      (op_a),
    .o_Op_B      (op_b),
    .o_Mul_Start (mul_start),
    .i_Mul_Done  (mul_done),
    .i_Mul_Result(mul_result),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Done   (tx_done),
    .o_Result    (result),
    .o_Busy      (busy),
    .o_Frame_Err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_start) st_cnt++;
      if (tx_dv)     tx_cnt++;
      if (frame_err) er_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic itick(input bit inj);
    if (inj && $urandom_range(0, 3) == 0) begin
      rx_dv   = 1'b1;
      rx_byte = 8'($urandom);
    end
    tick;
    rx_dv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick;
    rx_dv   = 1'b0;
  endtask

  // Sends a full frame with `gap` idle clocks between bytes, then checks the start pulse.
  task automatic send_frame(input logic [63:0] f, input int gap);
    int st0;
    st0 = st_cnt;
    for (int k = 0; k < 8; k++) begin
      send_byte(f[63-8*k -: 8]);
      if (k < 7) repeat (gap) tick;
    end
    chk("start_early", mul_start, 0);
    tick;
    chk("start_pulse", mul_start, 1);
    chk("op_a", op_a, f[63:32]);
    chk("op_b", op_b, f[31:0]);
    tick;
    chk("start_len", mul_start, 0);
    chk("busy_run", busy, 1);
    chk("start_once", st_cnt, st0 + 1);
    exp_a = f[63:32];
  endtask

  // Multiplier and transmitter responder; stops early (leaving the DUT mid-transmit) at abort_at.
  task automatic serve(input logic [31:0] res, input int dlen, input bit inj, input int abort_at);
    int tx0;
    tx0 = tx_cnt;
    if (inj) chk("busy_inj", busy, 1);
    repeat (3) itick(inj);
    mul_done   = 1'b1;
    mul_result = res;
    tick;
    chk("txdv_early", tx_dv, 0);
    if (dlen == 1) mul_done = 1'b0;
    tick;
    chk("txdv_first", tx_dv, 1);
    chk("tx_byte0", tx_byte, res[31:24]);
    chk("result", result, res);
    if (dlen > 2) repeat (dlen - 2) tick;
    mul_done = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == abort_at) return;
      repeat (20) itick(inj);
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      chk("txdv_gap", tx_dv, 0);
      tick;
      if (b < 3) begin
        chk("txdv_next", tx_dv, 1);
        chk("tx_byte", tx_byte, 32'(8'(res >> (8 * (2 - b)))));
      end else begin
        chk("txdv_end", tx_dv, 0);
        chk("busy_end", busy, 0);
      end
    end
    repeat (3) tick;
    chk("tx_count", tx_cnt, tx0 + 4);
  endtask

  function automatic logic [63:0] rnd_frame();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int e0;
    logic [7:0] p0, p1, p2;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_txdv", tx_dv, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_opa", op_a, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    tick;

    // Frame 3.0 x 2.0 at one byte per 1000 clocks.
    send_frame(64'h40400000_40000000, 999);
    serve(32'h40C00000, 1, 1'b0, 4);
    chk("no_err_1", er_cnt, 0);

    // Three bytes then silence: one discard pulse, partial bytes stay in A.
    e0 = er_cnt;
    p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
    send_byte(p0); repeat (10) tick;
    send_byte(p1); repeat (10) tick;
    send_byte(p2);
    repeat (T - 1) tick;
    chk("err_before", frame_err, 0);
    tick;
    chk("err_pulse", frame_err, 1);
    chk("partial_a", op_a, {p0, p1, p2, exp_a[7:0]});
    tick;
    chk("err_len", frame_err, 0);
    chk("err_count", er_cnt, e0 + 1);
    send_frame(64'h3F800000_3F800000, 5);
    serve(32'h3F800000, 1, 1'b0, 4);

    // A byte landing on the expiry cycle is kept and no error is raised.
    e0 = er_cnt;
    fr = rnd_frame();
    send_byte(fr[63:56]);
    repeat (T - 1) tick;
    for (int k = 1; k < 8; k++) begin
      send_byte(fr[63-8*k -: 8]);
      if (k < 7) repeat ($urandom_range(0, 20)) tick;
    end
    chk("exp_start_early", mul_start, 0);
    tick;
    chk("exp_start", mul_start, 1);
    chk("exp_op_a", op_a, fr[63:32]);
    chk("exp_op_b", op_b, fr[31:0]);
    tick;
    chk("exp_no_err", er_cnt, e0);
    serve($urandom, 1, 1'b0, 4);

    // Bytes arriving while busy are dropped.
    send_frame(rnd_frame(), $urandom_range(0, 15));
    serve($urandom, 1, 1'b1, 4);
    send_frame(rnd_frame(), $urandom_range(0, 15));
    serve($urandom, 1, 1'b0, 4);

    // Reset while waiting on the third transmitted byte.
    send_frame(rnd_frame(), 2);
    serve(32'hA5C3_5A3C, 1, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_txdv", tx_dv, 0);
    chk("arst_txbyte", tx_byte, 0);
    chk("arst_result", result, 0);
    chk("arst_opb", op_b, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    send_frame(rnd_frame(), $urandom_range(0, 15));
    serve($urandom, 1, 1'b0, 4);

    // Level-held done: single latch, four bytes only.
    send_frame(rnd_frame(), $urandom_range(0, 15));
    serve($urandom, 10, 1'b0, 4);
    chk("final_err_count", er_cnt, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
